// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the RV32I fetch stage: FSM encodings,
// the canonical NOP and the PC increment helper.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_KILL = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus: single-outstanding request pulse plus response.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_stage_skid.sv
// One-entry skid buffer for {instr, pc}; clear wins over load.
module if_skid_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);
    logic        valid_q;
    logic [31:0] instr_q, pc_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
        end
        if (rst) begin
            instr_q <= '0;
            pc_q    <= '0;
        end else if (load_i && !clear_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage with IF/ID register, decode-stall skid and redirect kill.
// Optional misaligned-target trap: define FETCH_MISALIGN_TRAP_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_stage_if.master        imem,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    input  logic                 stall_id,
    output logic                 id_valid,
    output logic [31:0]          id_instr,
    output logic [31:0]          id_pc,
    output logic [31:0]          id_pc_plus4,
    output logic                 id_fault
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, addr_q, addr_d;
    logic         req_q, req_d;
    logic         idv_q, idv_d, fault_q, fault_d;
    logic [31:0]  idi_q, idi_d, idpc_q, idpc_d, idpc4_q, idpc4_d;
    logic         skid_load, skid_clear, skid_valid;
    logic [31:0]  skid_instr, skid_pc;
    logic         misalign;
    logic [31:0]  tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign = (redirect_pc[1:0] != 2'b00);
    assign tgt      = redirect_pc;
`else
    assign misalign = 1'b0;
    assign tgt      = redirect_pc & ~32'h3;
`endif

    if_skid_reg u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .instr_i (imem.imem_rdata),
        .pc_i    (pc_q),
        .valid_o (skid_valid),
        .instr_o (skid_instr),
        .pc_o    (skid_pc)
    );

    always_comb begin
        state_d = state_q;   pc_d = pc_q;       req_d = 1'b0;     addr_d = addr_q;
        idv_d = idv_q;       idi_d = idi_q;     idpc_d = idpc_q;  idpc4_d = idpc4_q;
        fault_d = fault_q;   skid_load = 1'b0;  skid_clear = 1'b0;
        if (!stall_id) begin
            idv_d = 1'b0; idi_d = NOP_INSTR; fault_d = 1'b0;
        end
        case (state_q)
            // Entering S_REQ with a new pc already drives the pulse; req_q=0
            // here only after reset, so issue it now.
            S_REQ: if (!req_q) begin
                req_d = 1'b1; addr_d = pc_q;
            end else begin
                state_d = S_WAIT;
            end
            S_WAIT: if (imem.imem_rvalid) begin
                if (!idv_q || !stall_id) begin
                    idv_d = 1'b1; idi_d = imem.imem_rdata; fault_d = 1'b0;
                    idpc_d = pc_q; idpc4_d = pc_inc(pc_q);
                    pc_d = pc_inc(pc_q); req_d = 1'b1; addr_d = pc_inc(pc_q);
                    state_d = S_REQ;
                end else begin
                    skid_load = 1'b1; state_d = S_HOLD;
                end
            end
            // An empty skid in S_HOLD means a parked misaligned fault.
            S_HOLD: if (skid_valid && !stall_id) begin
                idv_d = 1'b1; idi_d = skid_instr; fault_d = 1'b0;
                idpc_d = skid_pc; idpc4_d = pc_inc(skid_pc); skid_clear = 1'b1;
                pc_d = pc_inc(pc_q); req_d = 1'b1; addr_d = pc_inc(pc_q);
                state_d = S_REQ;
            end
            S_KILL: if (imem.imem_rvalid) begin
                req_d = 1'b1; addr_d = pc_q; state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        if (redirect_valid) begin
            idv_d = 1'b0; idi_d = NOP_INSTR; fault_d = 1'b0;
            skid_load = 1'b0; skid_clear = 1'b1; pc_d = tgt;
            req_d = 1'b0; addr_d = addr_q;
            // A same-cycle rvalid retires the outstanding request even in S_KILL.
            if (state_q == S_WAIT || state_q == S_KILL)
                state_d = imem.imem_rvalid ? S_REQ : S_KILL;
            else if (state_q == S_REQ && req_q)
                state_d = S_KILL;
            else
                state_d = S_REQ;
            if (state_d == S_REQ) begin
                req_d = 1'b1; addr_d = tgt;
            end
            if (misalign) begin
                state_d = S_HOLD; req_d = 1'b0; addr_d = addr_q;
                idv_d = 1'b1; fault_d = 1'b1; idi_d = NOP_INSTR;
                idpc_d = redirect_pc; idpc4_d = pc_inc(redirect_pc);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;     pc_q <= RESET_PC;   req_q <= 1'b0;  addr_q <= RESET_PC;
            idv_q <= 1'b0;        idi_q <= NOP_INSTR; idpc_q <= '0;   idpc4_q <= 32'd4;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;   pc_q <= pc_d;       req_q <= req_d; addr_q <= addr_d;
            idv_q <= idv_d;       idi_q <= idi_d;     idpc_q <= idpc_d; idpc4_q <= idpc4_d;
            fault_q <= fault_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign id_valid       = idv_q;
    assign id_instr       = idi_q;
    assign id_pc          = idpc_q;
    assign id_pc_plus4    = idpc4_q;
    assign id_fault       = fault_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable memory responder.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_id;
    logic        id_valid, id_fault;
    logic [31:0] id_instr, id_pc, id_pc_plus4;

    int          nchk = 0;
    int          nerr = 0;
    int          lat  = 1;
    int          cnt  = 0;
    logic [31:0] paddr = '0;
    logic        resp_v = 1'b0;
    logic [31:0] resp_d = '0;

    fetch_stage_if mem ();
    assign mem.imem_rvalid = resp_v;
    assign mem.imem_rdata  = resp_d;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (mem),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_id       (stall_id),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_fault       (id_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : ((a << 8) | 32'h13);
    endfunction

    // Memory model: response lands lat cycles after the cycle of the request.
    always @(posedge clk) begin
        resp_v <= 1'b0;
        if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                resp_v <= 1'b1;
                resp_d <= memf(paddr);
            end
        end
        if (mem.imem_req) begin
            paddr = mem.imem_addr;
            if (lat == 1) begin
                resp_v <= 1'b1;
                resp_d <= memf(mem.imem_addr);
            end else begin
                cnt = lat - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; stall_id = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        tick();                                         // cycle 0: reset
        chk("rst_req", {31'b0, mem.imem_req}, 32'd0);
        chk("rst_addr", mem.imem_addr, 32'h0);
        chk("rst_vld", {31'b0, id_valid}, 32'd0);
        chk("rst_instr", id_instr, NOP);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_pc4", id_pc_plus4, 32'h4);
        chk("rst_fault", {31'b0, id_fault}, 32'd0);
        rst = 1'b0;

        tick();                                         // cycle 1
        chk("c1_req", {31'b0, mem.imem_req}, 32'd1);
        chk("c1_addr", mem.imem_addr, 32'h0);
        tick();                                         // cycle 2
        chk("c2_req", {31'b0, mem.imem_req}, 32'd0);
        chk("c2_vld", {31'b0, id_valid}, 32'd0);
        tick();                                         // cycle 3
        chk("c3_vld", {31'b0, id_valid}, 32'd1);
        chk("c3_instr", id_instr, 32'h0050_0093);
        chk("c3_pc", id_pc, 32'h0);
        chk("c3_pc4", id_pc_plus4, 32'h4);
        chk("c3_req", {31'b0, mem.imem_req}, 32'd1);
        chk("c3_addr", mem.imem_addr, 32'h4);

        stall_id = 1'b1;
        for (int i = 0; i < 5; i++) begin               // cycles 4..8
            tick();
            chk("stall_req", {31'b0, mem.imem_req}, 32'd0);
            chk("stall_pc", id_pc, 32'h0);
            chk("stall_instr", id_instr, 32'h0050_0093);
        end
        stall_id = 1'b0;
        tick();                                         // cycle 9
        chk("rel_pc", id_pc, 32'h4);
        chk("rel_instr", id_instr, 32'h0000_0413);
        chk("rel_req", {31'b0, mem.imem_req}, 32'd1);
        chk("rel_addr", mem.imem_addr, 32'h8);
        tick();                                         // cycle 10
        chk("drain_vld", {31'b0, id_valid}, 32'd0);
        chk("drain_instr", id_instr, NOP);
        tick();                                         // cycle 11
        chk("c11_pc", id_pc, 32'h8);
        lat = 3;
        tick();                                         // cycle 12 (S_WAIT)
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();                                         // cycle 13
        redirect_valid = 1'b0;
        chk("kill_vld13", {31'b0, id_valid}, 32'd0);
        chk("kill_req13", {31'b0, mem.imem_req}, 32'd0);
        tick();                                         // cycle 14
        chk("kill_vld14", {31'b0, id_valid}, 32'd0);
        tick();                                         // cycle 15
        chk("redir_req", {31'b0, mem.imem_req}, 32'd1);
        chk("redir_addr", mem.imem_addr, 32'h100);
        chk("kill_vld15", {31'b0, id_valid}, 32'd0);
        repeat (4) tick();                              // cycle 19
        chk("redir_vld", {31'b0, id_valid}, 32'd1);
        chk("redir_pc", id_pc, 32'h100);
        chk("redir_instr", id_instr, 32'h0001_0013);

        stall_id = 1'b1;
        repeat (2) tick();                              // cycle 21
        chk("hold_pc21", id_pc, 32'h100);
        tick();                                         // cycle 22: rvalid
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();                                         // cycle 23
        redirect_valid = 1'b0; stall_id = 1'b0;
        chk("coin_vld", {31'b0, id_valid}, 32'd0);
        chk("coin_instr", id_instr, NOP);
        chk("coin_req", {31'b0, mem.imem_req}, 32'd1);
        chk("coin_addr", mem.imem_addr, 32'h200);

        tick();                                         // cycle 24 (S_WAIT)
        rst = 1'b1;
        tick();                                         // cycle 25
        rst = 1'b0;
        chk("mrst_vld", {31'b0, id_valid}, 32'd0);
        chk("mrst_req", {31'b0, mem.imem_req}, 32'd0);
        tick();                                         // cycle 26: stray rvalid
        chk("mrst_req26", {31'b0, mem.imem_req}, 32'd1);
        chk("mrst_addr26", mem.imem_addr, 32'h0);
        tick();                                         // cycle 27
        chk("stray_vld", {31'b0, id_valid}, 32'd0);
        chk("stray_instr", id_instr, NOP);
        chk("stray_pc", id_pc, 32'h0);
        repeat (3) tick();                              // cycle 30
        chk("mrst_fetch_vld", {31'b0, id_valid}, 32'd1);
        chk("mrst_fetch_instr", id_instr, 32'h0050_0093);

        lat = 1;
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();                                         // cycle 31
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_vld", {31'b0, id_valid}, 32'd1);
        chk("mis_fault", {31'b0, id_fault}, 32'd1);
        chk("mis_pc", id_pc, 32'h102);
        chk("mis_instr", id_instr, NOP);
        chk("mis_req31", {31'b0, mem.imem_req}, 32'd0);
        stall_id = 1'b1;
        tick();                                         // cycle 32
        chk("mis_hold_fault", {31'b0, id_fault}, 32'd1);
        chk("mis_hold_pc", id_pc, 32'h102);
        stall_id = 1'b0;
        for (int i = 0; i < 2; i++) begin               // cycles 33..34
            tick();
            chk("mis_park_req", {31'b0, mem.imem_req}, 32'd0);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();                                         // cycle 35
        redirect_valid = 1'b0;
        chk("mis_exit_req", {31'b0, mem.imem_req}, 32'd1);
        chk("mis_exit_addr", mem.imem_addr, 32'h200);
        chk("mis_exit_fault", {31'b0, id_fault}, 32'd0);
`else
        chk("al_vld31", {31'b0, id_valid}, 32'd0);
        chk("al_fault31", {31'b0, id_fault}, 32'd0);
        tick();                                         // cycle 32
        chk("al_req", {31'b0, mem.imem_req}, 32'd1);
        chk("al_addr", mem.imem_addr, 32'h100);
        repeat (2) tick();                              // cycle 34
        chk("al_vld", {31'b0, id_valid}, 32'd1);
        chk("al_pc", id_pc, 32'h100);
        chk("al_fault", {31'b0, id_fault}, 32'd0);
`endif
        tick();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- RV32I instruction fetch stage plus IF/ID pipeline register.
- Owns the PC and a single-outstanding-request instruction-memory interface.
- Drives the decode stage. id_instr[31:7] feeds imm_gen directly, and the decoder derives imm_mux from id_instr.
- Handles decode stalls with a one-entry skid buffer, and branch/jump redirects with flush and kill of in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction driven on id_instr when the slot is empty or flushed (addi x0,x0,0).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- imem_req  out  1  one-cycle request pulse.
- imem_addr  out  32  fetch address; valid while imem_req=1.
- imem_rvalid  in  1  response valid, exactly one per request, at least 1 cycle after the request.
- imem_rdata  in  32  instruction word; valid with imem_rvalid.
- redirect_valid  in  1  taken branch/jump from EX; one-cycle pulse.
- redirect_pc  in  32  target PC.
- stall_id  in  1  decode cannot accept; the IF/ID register holds.
- id_valid  out  1  id_instr/id_pc are valid.
- id_instr  out  32  instruction to decode/imm_gen.
- id_pc  out  32  PC of id_instr.
- id_pc_plus4  out  32  id_pc+4.
- id_fault  out  1  misaligned-fetch fault flag (see Optional Feature).

Behaviour:
- Reset values (applied on the next clk edge with rst=1): state=S_REQ, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=4, id_fault=0, skid empty, kill=0.
- All outputs are registered.
- FSM states:
  - S_REQ: assert imem_req=1 and imem_addr=pc for one cycle -> S_WAIT.
  - S_WAIT: wait for imem_rvalid.
    - On rvalid with ID free (id_valid=0 or stall_id=0): load ID register (id_instr=rdata, id_pc=pc, id_valid=1), pc+=4 -> S_REQ.
    - On rvalid with ID occupied and stall_id=1: write to the skid buffer -> S_HOLD.
  - S_HOLD: no requests issued. When stall_id=0, the ID register loads from the skid, pc+=4 -> S_REQ.
  - S_KILL: request outstanding but flushed. The next rvalid is dropped -> S_REQ.
- ID register behaviour:
  - With stall_id=0 and no new data, id_valid falls to 0 and id_instr=NOP_INSTR on the cycle after consumption.
  - With stall_id=1, all id_* outputs hold.
- Throughput: 1 instruction per 2 cycles with 1-cycle memory. Fetch latency is req-to-id_valid = memory latency + 1.
- Redirect:
  - Redirect has priority over stall and over rvalid in the same cycle.
  - On redirect, next cycle: id_valid=0, id_instr=NOP_INSTR, skid cleared, pc=redirect_pc.
  - Next state on redirect: from S_WAIT without a same-cycle rvalid -> S_KILL. From S_WAIT with a same-cycle rvalid (data dropped), S_HOLD, or S_REQ -> S_REQ.
  - A redirect in S_REQ cancels the pending pulse. Any pulse already driven this cycle is followed by S_KILL.
  - A redirect in S_KILL updates pc and stays in S_KILL.
- rvalid arriving in S_REQ or S_HOLD (no outstanding request) is ignored.
- rst mid-operation returns to reset values. Any response to a pre-reset request arrives in S_REQ and is therefore ignored.
- PC arithmetic is modulo 2^32; pc=32'hFFFF_FFFC wraps to 0.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 performs no fetch.
  - Next cycle: id_valid=1, id_fault=1, id_pc=redirect_pc, id_instr=NOP_INSTR.
  - The FSM parks in S_HOLD until the next redirect. The fault entry holds under stall_id.
- Undefined:
  - redirect_pc[1:0] is forced to 2'b00 before use.
  - id_fault is tied 0.

Decomposition:
- Def.v gains the FSM state encodings (S_REQ, S_WAIT, S_HOLD, S_KILL, 2-bit) and NOP_INSTR.
- One sub-module, if_skid_reg: a one-entry skid buffer holding {instr, pc} with load/clear/valid.

Test Plan:
- Reset, 1-cycle memory returning 32'h00500093 at addr 0:
  - imem_req at cycle 1 with addr 0.
  - id_valid=1, id_instr=32'h00500093, id_pc=0 at cycle 3.
  - Next request at addr 4 at cycle 3.
- Stall:
  - Hold stall_id=1 for 5 cycles while the 2nd response (addr 4) returns: the ID register is unchanged, the skid captures it, and no imem_req is issued.
  - Release stall_id: id_pc=4 one cycle later, then a request at addr 8.
- Redirect in S_WAIT to 32'h0000_0100, with a 3-cycle memory:
  - The late response is dropped, id_valid stays 0.
  - The next imem_addr is 32'h100.
  - The instruction appears with id_pc=32'h100.
- Redirect coincident with rvalid and stall_id=1: ID is flushed (id_valid=0, id_instr=NOP_INSTR), the data is discarded, and the next request goes to redirect_pc.
- Reset asserted in S_WAIT: the next request goes to RESET_PC, and a stray rvalid in S_REQ has no effect on id_*.
- Redirect to 32'h0000_0102:
  - With FETCH_MISALIGN_TRAP_EN: id_fault=1, id_pc=32'h102, and no imem_req until the next redirect.
  - Without it: fetch at 32'h100, id_fault=0.
